muldiv_unit: RTL

Iterative RV32M multiply/divide unit in the EX stage, operating alongside the ALU. It receives the same forwarded operands a/b and computes MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM and REMU. The hazard unit uses its stall output to freeze IF/ID/EX while it runs. Its result is muxed with the ALU r output into the EX/MEM register.

---
 rtl/muldiv_unit_pkg.sv | 37 +++
 rtl/muldiv_step.sv | 53 +++++
 rtl/muldiv_unit.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg
//   Shared definitions for the RV32M multiply/divide unit:
//   - funct3 codes for the eight M-extension operations
//   - funct7 value that marks an OP-class instruction as M-extension
//   - FSM state type
//   - helpers that say which operands an operation treats as signed
package muldiv_unit_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  localparam logic [6:0] MD_OPCODE_FUNCT7 = 7'b0000001;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_FIN  = 2'd2
  } md_state_e;

  // rs1 is signed for every signed multiply flavour and for DIV/REM
  function automatic logic op_a_signed(input logic [2:0] f);
    return (f == MD_MUL) || (f == MD_MULH) || (f == MD_MULHSU) ||
           (f == MD_DIV) || (f == MD_REM);
  endfunction

  // rs2 is signed only when both operands are signed
  function automatic logic op_b_signed(input logic [2:0] f);
    return (f == MD_MUL) || (f == MD_MULH) || (f == MD_DIV) || (f == MD_REM);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step
//   One combinational iteration over the {acc, q} register pair.
//   Multiply (is_div=0): shift-add. If q[0] is set, m is added into acc;
//     the whole {carry, acc, q} is then shifted right by one.
//   Divide (is_div=1): restoring. {acc, q} shifts left by one, m is
//     subtracted from the upper part when it fits, and the quotient bit
//     enters at q[0].
// Ports:
//   is_div            selects divide step vs multiply step
//   acc, q            current partial product / partial remainder + quotient
//   m                 multiplicand magnitude or divisor magnitude
//   acc_next, q_next  register values after this iteration
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] acc,
  input  logic [XLEN-1:0] q,
  input  logic [XLEN-1:0] m,
  output logic [XLEN-1:0] acc_next,
  output logic [XLEN-1:0] q_next
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic [XLEN-1:0] diff;

  // The remainder is always below m, so after a successful subtract
  // the difference fits in XLEN bits and the borrow bit can be dropped.
  always_comb begin
    sum      = {1'b0, acc} + {1'b0, m};
    shifted  = {acc, q[XLEN-1]};
    diff     = shifted[XLEN-1:0] - m;
    acc_next = acc;
    q_next   = q;
    if (is_div) begin
      if (shifted >= {1'b0, m}) begin
        acc_next = diff;
        q_next   = {q[XLEN-2:0], 1'b1};
      end else begin
        acc_next = shifted[XLEN-1:0];
        q_next   = {q[XLEN-2:0], 1'b0};
      end
    end else if (q[0]) begin
      acc_next = sum[XLEN:1];
      q_next   = {sum[0], q[XLEN-1:1]};
    end else begin
      acc_next = {1'b0, acc[XLEN-1:1]};
      q_next   = {acc[0], q[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative RV32M multiply/divide unit sitting beside the ALU in EX.
//   Operands are reduced to magnitudes on accept, XLEN iterations of
//   muldiv_step run in CALC, and the sign fix-up is folded into the last
//   iteration so result and done appear together in FIN.
//   Divide-by-zero and signed overflow skip CALC entirely.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   start        valid M-extension instruction in EX (looked at in IDLE only)
//   funct3       RV32M operation select
//   a, b         forwarded rs1 / rs2
//   flush        EX flush; abandons the operation
//   stall        combinational pipeline hold for the hazard unit
//   busy         registered, high in CALC and FIN
//   done         registered one-cycle pulse, result valid
//   result       registered result, held until the next finished operation
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);

  md_state_e       state, state_next;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] acc, q, m;
  logic [2:0]      op;
  logic            neg_q, neg_r;
  logic            accept, last;

  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            b_zero, overflow, special;
  logic [XLEN-1:0] special_res;

  logic [XLEN-1:0]   acc_nx, q_nx;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo, rem, mul_res, div_res, calc_res;

  assign a_neg = op_a_signed(funct3) & a[XLEN-1];
  assign b_neg = op_b_signed(funct3) & b[XLEN-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign b_zero   = (b == '0);
  assign overflow = ((funct3 == MD_DIV) || (funct3 == MD_REM)) &&
                    (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
  assign special  = funct3[2] & (b_zero | overflow);

  // funct3[1] separates the remainder ops from the quotient ops
  assign special_res = b_zero ? (funct3[1] ? a : '1)
                              : (funct3[1] ? '0 : a);

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (op[2]),
    .acc     (acc),
    .q       (q),
    .m       (m),
    .acc_next(acc_nx),
    .q_next  (q_nx)
  );

  assign prod     = {acc_nx, q_nx};
  assign prod_fix = neg_q ? -prod : prod;
  assign mul_res  = (op == MD_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
  assign quo      = neg_q ? -q_nx : q_nx;
  assign rem      = neg_r ? -acc_nx : acc_nx;
  assign div_res  = op[1] ? rem : quo;
  assign calc_res = op[2] ? div_res : mul_res;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_next;
  end

  // Next state and pipeline stall. A flush in IDLE wins over start;
  // a flush in CALC abandons the iteration before anything is written.
  always_comb begin
    state_next = state;
    stall      = 1'b0;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      MD_IDLE: begin
        if (start && !flush) begin
          stall      = 1'b1;
          accept     = 1'b1;
          state_next = special ? MD_FIN : MD_CALC;
        end
      end
      MD_CALC: begin
        stall = 1'b1;
        if (flush) begin
          state_next = MD_IDLE;
        end else if (count == CW'(XLEN-1)) begin
          last       = 1'b1;
          state_next = MD_FIN;
        end
      end
      MD_FIN:  state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one iteration per CALC cycle.
  // The final, sign-corrected value is registered on the edge into FIN
  // so result and done are valid during the FIN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      acc    <= '0;
      q      <= '0;
      m      <= '0;
      op     <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
    end else begin
      done <= 1'b0;
      busy <= (state_next != MD_IDLE);
      if (accept) begin
        op    <= funct3;
        neg_q <= a_neg ^ b_neg;
        neg_r <= a_neg;
        acc   <= '0;
        q     <= a_mag;
        m     <= b_mag;
        count <= '0;
        if (special) begin
          result <= special_res;
          done   <= 1'b1;
        end
      end else if (state == MD_CALC && !flush) begin
        acc   <= acc_nx;
        q     <= q_nx;
        count <= count + 1'b1;
        if (last) begin
          result <= calc_res;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule
